// File: rtl/zeroriscy_multdiv_iter_if.sv
// Bundle between the EX stage, the ALU adder and the iterative multiplier/divider.
// Signals:
//   mult_en_i, div_en_i      : operation requests, held high until ready_o
//   operator_i               : MD_OP_* code (MULL/MULH/DIV/REM)
//   signed_mode_i            : [0] operand a signed, [1] operand b signed
//   op_a_i, op_b_i           : rs1 / rs2 values, stable while a request is high
//   alu_adder_ext_i          : 34-bit extended adder result returned by the ALU
//   alu_operand_a_o/_b_o     : 33-bit operands driven into the ALU adder
//   alu_sel_o                : claims the ALU adder for the multdiv unit
//   ready_o                  : result valid this cycle
//   multdiv_result_o         : 32-bit result
// master = EX stage / ALU side, slave = the multdiv unit.
interface zeroriscy_multdiv_iter_if;
    logic        mult_en_i;
    logic        div_en_i;
    logic [1:0]  operator_i;
    logic [1:0]  signed_mode_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [33:0] alu_adder_ext_i;
    logic [32:0] alu_operand_a_o;
    logic [32:0] alu_operand_b_o;
    logic        alu_sel_o;
    logic        ready_o;
    logic [31:0] multdiv_result_o;

    modport master (
        output mult_en_i, div_en_i, operator_i, signed_mode_i, op_a_i, op_b_i,
               alu_adder_ext_i,
        input  alu_operand_a_o, alu_operand_b_o, alu_sel_o, ready_o, multdiv_result_o
    );

    modport slave (
        input  mult_en_i, div_en_i, operator_i, signed_mode_i, op_a_i, op_b_i,
               alu_adder_ext_i,
        output alu_operand_a_o, alu_operand_b_o, alu_sel_o, ready_o, multdiv_result_o
    );
endinterface

// File: rtl/zeroriscy_multdiv_iter.sv
// Iterative multiplier/divider for the EX stage. Every add/subtract is performed
// by the ALU adder: X+Y+cin is requested as operand_a={X,1}, operand_b={Y,cin},
// and the 33-bit sum comes back on alu_adder_ext_i[33:1].
// Multiply: radix-2 shift-add over 32 cycles, plus one sign-correction cycle for
// MULH*. Divide: operand magnitudes, 32 restoring steps, then a sign fix.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   md    : slave side of zeroriscy_multdiv_iter_if (requests, ALU link, result)
module zeroriscy_multdiv_iter (
    input logic clk,
    input logic rst_n,
    zeroriscy_multdiv_iter_if.slave md
);

    localparam logic [1:0] MD_OP_MULL = 2'b00;
    localparam logic [1:0] MD_OP_MULH = 2'b01;
    localparam logic [1:0] MD_OP_DIV  = 2'b10;
    localparam logic [1:0] MD_OP_REM  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, MUL_COMP, MUL_LAST, ABS_A, ABS_B, DIV_COMP, CHANGE_SIGN, FINISH
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  counter_reg, counter_next;
    logic [31:0] acc_reg, acc_next;        // product high half / remainder
    logic [31:0] a_reg, a_next;            // multiplicand / dividend, then quotient
    logic [31:0] b_reg, b_next;            // multiplier, then product low half / |divisor|
    logic [31:0] result_reg, result_next;
    logic [1:0]  op_reg, op_next;
    logic        div_mode_reg, div_mode_next;
    logic        sign_a_reg, sign_a_next;
    logic        a_neg_reg, a_neg_next;
    logic        b_neg_reg, b_neg_next;
    logic        b_zero_reg, b_zero_next;

    logic [31:0] alu_x, alu_y;
    logic        alu_cin;
    logic        alu_sel;
    logic [31:0] sum_lo;
    logic        carry;
    logic        active_en;
    logic        mul_top;
    logic [31:0] rem_shift;
    logic        keep;
    logic        fix_is_rem, fix_is_quot, fix_neg;
    logic [31:0] fix_val;
    logic        unused_ext_lsb;

    assign sum_lo         = md.alu_adder_ext_i[32:1];
    assign carry          = md.alu_adder_ext_i[33];
    assign unused_ext_lsb = md.alu_adder_ext_i[0];

    assign active_en = div_mode_reg ? md.div_en_i : md.mult_en_i;

    // Bit 32 of the partial-product sum. With a signed multiplicand the
    // accumulator is a signed value, so the true 33rd bit is the sign-extended
    // sum of both top bits plus the carry out of bit 31.
    assign mul_top = sign_a_reg ? (acc_reg[31] ^ (b_reg[0] & a_reg[31]) ^ carry) : carry;

    // Restoring step: shift the next dividend bit into the remainder. If the
    // remainder's top bit was set, the shifted value is >= 2^32 > |b|, so the
    // subtraction must be kept even though the 32-bit subtract borrows.
    assign rem_shift = {acc_reg[30:0], a_reg[31]};
    assign keep      = carry | acc_reg[31];

    // Final sign fix: quotient negated when signs differ (except divide by zero,
    // which must stay all ones), remainder takes the dividend's sign.
    assign fix_is_rem  = (op_reg == MD_OP_REM);
    assign fix_is_quot = (op_reg == MD_OP_DIV);
    assign fix_val     = fix_is_rem ? acc_reg : a_reg;
    assign fix_neg     = fix_is_rem ? a_neg_reg
                                    : (fix_is_quot & (a_neg_reg ^ b_neg_reg) & ~b_zero_reg);

    // ALU operand selection depends only on registered state.
    always_comb begin
        alu_x   = '0;
        alu_y   = '0;
        alu_cin = 1'b0;
        alu_sel = 1'b1;
        case (state_reg)
            MUL_COMP: begin
                alu_x = acc_reg;
                alu_y = b_reg[0] ? a_reg : '0;
            end
            MUL_LAST: begin
                alu_x   = acc_reg;
                alu_y   = b_neg_reg ? ~a_reg : '0;
                alu_cin = b_neg_reg;
            end
            ABS_A: begin
                alu_y   = a_neg_reg ? ~a_reg : a_reg;
                alu_cin = a_neg_reg;
            end
            ABS_B: begin
                alu_y   = b_neg_reg ? ~b_reg : b_reg;
                alu_cin = b_neg_reg;
            end
            DIV_COMP: begin
                alu_x   = rem_shift;
                alu_y   = ~b_reg;
                alu_cin = 1'b1;
            end
            CHANGE_SIGN: begin
                alu_y   = fix_neg ? ~fix_val : fix_val;
                alu_cin = fix_neg;
            end
            default: alu_sel = 1'b0;
        endcase
    end

    assign md.alu_sel_o        = alu_sel;
    assign md.alu_operand_a_o  = alu_sel ? {alu_x, 1'b1} : '0;
    assign md.alu_operand_b_o  = alu_sel ? {alu_y, alu_cin} : '0;
    assign md.ready_o          = (state_reg == FINISH);
    assign md.multdiv_result_o = result_reg;

    // Next-state and datapath register updates.
    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        acc_next      = acc_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        result_next   = result_reg;
        op_next       = op_reg;
        div_mode_next = div_mode_reg;
        sign_a_next   = sign_a_reg;
        a_neg_next    = a_neg_reg;
        b_neg_next    = b_neg_reg;
        b_zero_next   = b_zero_reg;

        case (state_reg)
            IDLE: begin
                if (md.mult_en_i || md.div_en_i) begin
                    op_next       = md.operator_i;
                    div_mode_next = ~md.mult_en_i;
                    a_next        = md.op_a_i;
                    b_next        = md.op_b_i;
                    acc_next      = '0;
                    counter_next  = 5'd31;
                    sign_a_next   = md.signed_mode_i[0];
                    a_neg_next    = md.signed_mode_i[0] & md.op_a_i[31];
                    b_neg_next    = md.signed_mode_i[1] & md.op_b_i[31];
                    b_zero_next   = (md.op_b_i == 32'd0);
                    state_next    = md.mult_en_i ? MUL_COMP : ABS_A;
                end
            end
            MUL_COMP: begin
                // Shift the sum right: its LSB becomes the next product low bit,
                // entering at the top of b_reg as the consumed multiplier bit leaves.
                acc_next     = {mul_top, sum_lo[31:1]};
                b_next       = {sum_lo[0], b_reg[31:1]};
                counter_next = counter_reg - 5'd1;
                if (counter_reg == 5'd0) begin
                    case (op_reg)
                        MD_OP_MULL: begin
                            result_next = {sum_lo[0], b_reg[31:1]};
                            state_next  = FINISH;
                        end
                        MD_OP_MULH: state_next = MUL_LAST;
                        default: begin
                            result_next = {sum_lo[0], b_reg[31:1]};
                            state_next  = FINISH;
                        end
                    endcase
                end
            end
            MUL_LAST: begin
                // A negative signed b carries weight -2^32 in its sign bit,
                // so a is subtracted from the high half once.
                result_next = sum_lo;
                state_next  = FINISH;
            end
            ABS_A: begin
                a_next     = sum_lo;
                state_next = ABS_B;
            end
            ABS_B: begin
                b_next       = sum_lo;
                counter_next = 5'd31;
                state_next   = DIV_COMP;
            end
            DIV_COMP: begin
                acc_next     = keep ? sum_lo : rem_shift;
                a_next       = {a_reg[30:0], keep};
                counter_next = counter_reg - 5'd1;
                if (counter_reg == 5'd0) begin
                    state_next = CHANGE_SIGN;
                end
            end
            CHANGE_SIGN: begin
                result_next = sum_lo;
                state_next  = FINISH;
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Requester withdrew: abandon the operation without producing a result.
        if (state_reg != IDLE && state_reg != FINISH && !active_en) begin
            state_next  = IDLE;
            result_next = result_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            counter_reg  <= '0;
            acc_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            result_reg   <= '0;
            op_reg       <= '0;
            div_mode_reg <= 1'b0;
            sign_a_reg   <= 1'b0;
            a_neg_reg    <= 1'b0;
            b_neg_reg    <= 1'b0;
            b_zero_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            counter_reg  <= counter_next;
            acc_reg      <= acc_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            result_reg   <= result_next;
            op_reg       <= op_next;
            div_mode_reg <= div_mode_next;
            sign_a_reg   <= sign_a_next;
            a_neg_reg    <= a_neg_next;
            b_neg_reg    <= b_neg_next;
            b_zero_reg   <= b_zero_next;
        end
    end

endmodule

// File: tb/tb_zeroriscy_multdiv_iter.sv
// Testbench for zeroriscy_multdiv_iter: an ALU adder model closes the operand
// loop; results are compared against a plain-arithmetic reference model.
module tb_zeroriscy_multdiv_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    zeroriscy_multdiv_iter_if md();

    // ALU adder: plain 34-bit sum of the two 33-bit operands.
    assign md.alu_adder_ext_i = {1'b0, md.alu_operand_a_o} + {1'b0, md.alu_operand_b_o};

    zeroriscy_multdiv_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [1:0] sm,
                                            input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] ea, eb, p;
        ea = {{34{sm[0] & a[31]}}, a};
        eb = {{34{sm[1] & b[31]}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [1:0] sm,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sm == 2'b11) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return (op == 2'b11) ? r : q;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drive one request (called at #1 after a rising edge) and follow it until
    // ready_o; returns at #1 into the cycle after FINISH with requests dropped.
    task automatic do_op(input bit is_div, input logic [1:0] op, input logic [1:0] sm,
                         input logic [31:0] a, input logic [31:0] b,
                         output int rdy_cyc, output logic [31:0] res,
                         output int sel_first, output int sel_last, output int sel_cnt);
        md.mult_en_i     = !is_div;
        md.div_en_i      = is_div;
        md.operator_i    = op;
        md.signed_mode_i = sm;
        md.op_a_i        = a;
        md.op_b_i        = b;
        rdy_cyc   = -1;
        res       = '0;
        sel_first = -1;
        sel_last  = -1;
        sel_cnt   = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (md.alu_sel_o === 1'b1) begin
                if (sel_first < 0) sel_first = c;
                sel_last = c;
                sel_cnt++;
            end
            if (md.ready_o === 1'b1) begin
                rdy_cyc = c;
                res     = md.multdiv_result_o;
            end
            @(posedge clk);
            #1;
            if (rdy_cyc >= 0) break;
        end
        md.mult_en_i = 1'b0;
        md.div_en_i  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        md.mult_en_i = 1'b0; md.div_en_i = 1'b0; md.operator_i = '0;
        md.signed_mode_i = '0; md.op_a_i = '0; md.op_b_i = '0;
        rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (md.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", md.ready_o); end
        if (md.alu_sel_o !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %b want 0", md.alu_sel_o); end
        if (md.alu_operand_a_o !== 33'd0) begin n_fail++; $display("FAIL reset_opa: got %h want 0", md.alu_operand_a_o); end
        if (md.alu_operand_b_o !== 33'd0) begin n_fail++; $display("FAIL reset_opb: got %h want 0", md.alu_operand_b_o); end
        if (md.multdiv_result_o !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", md.multdiv_result_o); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset: outputs checked");
    endtask

    task automatic test_mul();
        logic [1:0]  ops[4] = '{2'b00, 2'b01, 2'b01, 2'b01};
        logic [1:0]  sms[4] = '{2'b11, 2'b11, 2'b00, 2'b01};
        logic [31:0] as[4]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs[4]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] xs[4]  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [1:0]  modes[3] = '{2'b11, 2'b01, 2'b00};
        logic [1:0]  op, sm;
        logic [31:0] a, b, exp, res;
        int rc, sf, sl, sc, exp_lat;
        for (int i = 0; i < 24; i++) begin
            if (i < 4) begin
                op = ops[i]; sm = sms[i]; a = as[i]; b = bs[i]; exp = xs[i];
            end else begin
                op = 2'($urandom_range(0, 1));
                sm = modes[$urandom_range(0, 2)];
                a  = rand_operand();
                b  = rand_operand();
                exp = ref_mul(op, sm, a, b);
            end
            exp_lat = (op == 2'b00) ? 33 : 34;
            do_op(1'b0, op, sm, a, b, rc, res, sf, sl, sc);
            $display("mul op=%0d sm=%b a=%h b=%h -> %h (exp %h) ready@%0d", op, sm, a, b, res, exp, rc);
            n_checks += 2;
            if (res !== exp) begin n_fail++; $display("FAIL mul_result: got %h want %h", res, exp); end
            if (rc != exp_lat) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", rc, exp_lat); end
            if (i == 0) begin
                n_checks += 3;
                if (sf != 1) begin n_fail++; $display("FAIL mull_sel_first: got %0d want 1", sf); end
                if (sl != 32) begin n_fail++; $display("FAIL mull_sel_last: got %0d want 32", sl); end
                if (sc != 32) begin n_fail++; $display("FAIL mull_sel_count: got %0d want 32", sc); end
            end
        end
    endtask

    task automatic test_div();
        logic [1:0]  ops[8] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
        logic [1:0]  sms[8] = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11};
        logic [31:0] as[8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[8]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] xs[8]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'd0};
        logic [1:0]  op, sm;
        logic [31:0] a, b, exp, res;
        int rc, sf, sl, sc;
        for (int i = 0; i < 28; i++) begin
            if (i < 8) begin
                op = ops[i]; sm = sms[i]; a = as[i]; b = bs[i]; exp = xs[i];
            end else begin
                op = 2'($urandom_range(2, 3));
                sm = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
                a  = rand_operand();
                b  = rand_operand();
                exp = ref_div(op, sm, a, b);
            end
            do_op(1'b1, op, sm, a, b, rc, res, sf, sl, sc);
            $display("div op=%0d sm=%b a=%h b=%h -> %h (exp %h) ready@%0d", op, sm, a, b, res, exp, rc);
            n_checks += 2;
            if (res !== exp) begin n_fail++; $display("FAIL div_result: got %h want %h", res, exp); end
            if (rc != 36) begin n_fail++; $display("FAIL div_latency: got %0d want 36", rc); end
        end
    endtask

    task automatic test_abort();
        int seen_ready = 0;
        int rc, sf, sl, sc;
        logic [31:0] res;
        md.div_en_i = 1'b1; md.operator_i = 2'b10; md.signed_mode_i = 2'b11;
        md.op_a_i = 32'd1234; md.op_b_i = 32'd7;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (md.ready_o === 1'b1) seen_ready++;
            @(posedge clk);
            #1;
        end
        md.div_en_i = 1'b0;                     // cycle 10
        @(negedge clk);
        if (md.ready_o === 1'b1) seen_ready++;
        @(posedge clk);
        #1;                                     // cycle 11: back in IDLE
        n_checks += 3;
        if (seen_ready != 0) begin n_fail++; $display("FAIL abort_ready: got %0d pulses want 0", seen_ready); end
        if (md.alu_sel_o !== 1'b0) begin n_fail++; $display("FAIL abort_idle_sel: got %b want 0", md.alu_sel_o); end
        if (md.ready_o !== 1'b0) begin n_fail++; $display("FAIL abort_idle_ready: got %b want 0", md.ready_o); end
        do_op(1'b0, 2'b00, 2'b11, 32'd3, 32'd5, rc, res, sf, sl, sc);
        $display("abort then mull 3*5 -> %h ready@%0d", res, rc);
        n_checks += 2;
        if (res !== 32'd15) begin n_fail++; $display("FAIL abort_mull_result: got %h want 0000000f", res); end
        if (rc != 33) begin n_fail++; $display("FAIL abort_mull_latency: got %0d want 33", rc); end
    endtask

    task automatic test_reset_mid();
        int seen_ready = 0;
        md.mult_en_i = 1'b1; md.operator_i = 2'b00; md.signed_mode_i = 2'b11;
        md.op_a_i = $urandom; md.op_b_i = $urandom;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (md.ready_o !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b want 0", md.ready_o); end
        if (md.alu_sel_o !== 1'b0) begin n_fail++; $display("FAIL midreset_sel: got %b want 0", md.alu_sel_o); end
        if (md.alu_operand_a_o !== 33'd0) begin n_fail++; $display("FAIL midreset_opa: got %h want 0", md.alu_operand_a_o); end
        if (md.alu_operand_b_o !== 33'd0) begin n_fail++; $display("FAIL midreset_opb: got %h want 0", md.alu_operand_b_o); end
        if (md.multdiv_result_o !== 32'd0) begin n_fail++; $display("FAIL midreset_result: got %h want 0", md.multdiv_result_o); end
        md.mult_en_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (md.ready_o === 1'b1) seen_ready++;
        end
        n_checks++;
        if (seen_ready != 0) begin n_fail++; $display("FAIL midreset_no_ready: got %0d pulses want 0", seen_ready); end
        @(posedge clk);
        #1;
        $display("reset mid-operation: outputs checked");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, r1, r2, e1, e2;
        int rc1, rc2, sf, sl, sc;
        int extra = 0;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = 32'($urandom_range(1, 1000));
        e1 = ref_mul(2'b00, 2'b11, a1, b1);
        e2 = ref_div(2'b10, 2'b00, a2, b2);
        do_op(1'b0, 2'b00, 2'b11, a1, b1, rc1, r1, sf, sl, sc);
        do_op(1'b1, 2'b10, 2'b00, a2, b2, rc2, r2, sf, sl, sc);
        $display("b2b mull a=%h b=%h -> %h (exp %h) ready@%0d", a1, b1, r1, e1, rc1);
        $display("b2b divu a=%h b=%h -> %h (exp %h) ready@%0d", a2, b2, r2, e2, rc2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (md.ready_o === 1'b1) extra++;
        end
        n_checks += 5;
        if (r1 !== e1) begin n_fail++; $display("FAIL b2b_mull_result: got %h want %h", r1, e1); end
        if (rc1 != 33) begin n_fail++; $display("FAIL b2b_mull_latency: got %0d want 33", rc1); end
        if (r2 !== e2) begin n_fail++; $display("FAIL b2b_divu_result: got %h want %h", r2, e2); end
        if (rc2 != 36) begin n_fail++; $display("FAIL b2b_divu_latency: got %0d want 36", rc2); end
        if (extra != 0) begin n_fail++; $display("FAIL b2b_extra_ready: got %0d pulses want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zeroriscy_multdiv_iter.md
Name: zeroriscy_multdiv_iter

Overview:
- Iterative multiplier/divider in the EX stage, directly upstream of the ALU adder.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Drives the ALU's 33-bit multdiv operands and multdiv enable, and consumes the ALU's 34-bit extended adder result.
- Has no private adder: every add or subtract goes through the ALU.

Parameters:
- none (operand width fixed at 32; opcode encodings MD_OP_MULL=2'b00, MD_OP_MULH=2'b01, MD_OP_DIV=2'b10, MD_OP_REM=2'b11)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mult_en_i  in  1  multiply request; held high until ready_o
- div_en_i  in  1  divide request; held high until ready_o; never high together with mult_en_i
- operator_i  in  2  MD_OP_* code
- signed_mode_i  in  2  [0]=operand a signed, [1]=operand b signed
- op_a_i  in  32  rs1 value; stable while enable is high
- op_b_i  in  32  rs2 value; stable while enable is high
- alu_adder_ext_i  in  34  ALU adder_result_ext_o
- alu_operand_a_o  out  33  to ALU multdiv_operand_a_i
- alu_operand_b_o  out  33  to ALU multdiv_operand_b_i
- alu_sel_o  out  1  to ALU multdiv_en_i
- ready_o  out  1  result valid this cycle
- multdiv_result_o  out  32  result

Behaviour:
- Reset and clocking
  - Reset is asynchronous, active low, single clock domain.
  - Reset values: state=IDLE, counter=0, accumulator/quotient/operand registers=0, ready_o=0, alu_sel_o=0, operands=0, multdiv_result_o=0.
- Adder convention
  - To compute X+Y+cin (X, Y are 32 bit): alu_operand_a_o={X,1'b1}, alu_operand_b_o={Y,cin}.
  - The 33-bit sum is alu_adder_ext_i[33:1]; bit 33 is the carry.
  - Subtract: Y=~Y, cin=1.
- alu_sel_o
  - High in every state except IDLE and FINISH.
  - Operand outputs are 0 when alu_sel_o=0.
- States: IDLE, MUL_COMP, MUL_LAST, ABS_A, ABS_B, DIV_COMP, CHANGE_SIGN, FINISH.
- IDLE
  - On mult_en_i: latch operands, counter=31, go to MUL_COMP.
  - On div_en_i: latch operands, record b==0, go to ABS_A.
- MUL_COMP
  - Radix-2 shift-add, one partial product per cycle, counter decrements.
  - At counter==0: MULL goes to FINISH; MULH goes to MUL_LAST.
- MUL_LAST
  - Sign correction: subtract the partial product when b is signed and negative.
  - Go to FINISH.
- ABS_A / ABS_B
  - Negate the operand via the ALU if signed and negative.
  - counter=31, then go to DIV_COMP.
- DIV_COMP
  - Restoring division, one quotient bit per cycle.
  - Trial subtract remainder-|b|; keep the result when no borrow (carry=1).
  - At counter==0, go to CHANGE_SIGN.
- CHANGE_SIGN
  - Negate the quotient when signs differ (signed DIV).
  - Negate the remainder when a is negative (signed REM).
  - Go to FINISH.
- FINISH
  - ready_o=1 for exactly one cycle; multdiv_result_o valid.
  - Return to IDLE next cycle. A new request may be accepted in the following IDLE cycle.
- Latency, counting the request cycle as cycle 0 (constant regardless of data):
  - ready_o at cycle 33 for MULL.
  - ready_o at cycle 34 for MULH*.
  - ready_o at cycle 36 for DIV/REM.
- Results (RISC-V semantics)
  - MULL returns the low 32 bits.
  - MULH signed_mode 11 = MULH, 01 = MULHSU, 00 = MULHU.
  - DIV/REM signed_mode 11 = signed, 00 = unsigned.
  - Divide by zero: quotient=32'hFFFFFFFF; remainder=dividend.
  - Signed overflow (0x80000000 / -1): quotient=0x80000000, remainder=0.
- Abort
  - If the active enable drops in any non-IDLE state, return to IDLE next cycle.
  - ready_o is not asserted; internal registers are irrelevant afterwards.
- Reset mid-operation
  - Immediate return to reset values; no ready_o is produced.
- multdiv_result_o holds its last value outside FINISH; the consumer samples it only when ready_o=1.

Test Plan:
- MULL, signed_mode=11, a=7, b=0xFFFFFFFD -> ready_o at cycle 33 only, result 0xFFFFFFEB; alu_sel_o high in cycles 1-32.
- MULH family:
  - MULH 11, 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 00, 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 01, 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
  - Each ready at cycle 34.
- Signed divide:
  - DIV 11, a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD at cycle 36.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Corner cases:
  - DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - All at cycle 36.
- Abort and reset:
  - Drop div_en_i at cycle 10 -> IDLE at cycle 11, no ready_o.
  - Immediately issue MULL 3×5 -> 15 at cycle 33 relative to the new request.
  - Assert rst_n=0 mid-MUL_COMP -> outputs at reset values asynchronously.
- Back-to-back:
  - MULL then DIVU issued on the cycle after FINISH -> both results correct.
  - ready_o pulses exactly once per operation.
